// File: rtl/music_voice_bank.sv
// music_voice_bank
//   Bank of NUM_VOICES independent square-wave tone generators. Each voice
//   holds a programmable half-period. Global octave shift, tremolo gating
//   and LED blink are shared by all voices. The gated voices are mixed into
//   a 1-bit sigma-delta stream for the audio pin.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   wr_en        single-cycle period write strobe
//   wr_sel       voice index for the write
//   wr_period    half-period in clk cycles (0 mutes the voice)
//   octave_up    halve every effective half-period
//   octave_down  double every effective half-period
//   tremolo_en   gate voices with the LFO MSB
//   led_en       enable LED blink
//   voice_out    registered per-voice square waves after tremolo gating
//   mix_out      sigma-delta mix of voice_out (even voices in stereo build)
//   any_active   combinational OR of (period != 0) over all voices
//   led_out      registered activity LED
//   mix_out_r    stereo build only: sigma-delta mix of odd voices
//
// Build option
//   MUSIC_VOICE_BANK_STEREO_EN: adds mix_out_r and splits the mixer into an
//   even-voice channel (mix_out) and an odd-voice channel (mix_out_r), each
//   dividing by NUM_VOICES/2.
module music_voice_bank #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PERIOD_W   = 12,
    parameter int unsigned TREM_W     = 16,
    localparam int unsigned SEL_W     = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [PERIOD_W-1:0]   wr_period,
    input  logic                  octave_up,
    input  logic                  octave_down,
    input  logic                  tremolo_en,
    input  logic                  led_en,
    output logic [NUM_VOICES-1:0] voice_out,
    output logic                  mix_out,
    output logic                  any_active,
    output logic                  led_out
`ifdef MUSIC_VOICE_BANK_STEREO_EN
    ,
    output logic                  mix_out_r
`endif
);

    localparam int unsigned H_W   = PERIOD_W + 1;
    localparam int unsigned ACC_W = SEL_W + 1;
    localparam int unsigned SUM_W = SEL_W + 2;

    logic [NUM_VOICES-1:0][PERIOD_W-1:0] period_q, period_d;
    logic [NUM_VOICES-1:0][H_W-1:0]      cnt_q, cnt_d;
    logic [NUM_VOICES-1:0][H_W-1:0]      half_c;
    logic [NUM_VOICES-1:0]               raw_q, raw_d;
    logic [NUM_VOICES-1:0]               voice_q, voice_d;
    logic [TREM_W-1:0]                   lfo_q, lfo_d;
    logic [ACC_W-1:0]                    acc_q, acc_d;
    logic                                mix_q, mix_d;
    logic                                led_q, led_d;
    logic                                gate_c;

    // Effective half-period after octave shift; a nonzero period never maps to 0.
    function automatic logic [H_W-1:0] eff_half(input logic [PERIOD_W-1:0] p,
                                                input logic                up,
                                                input logic                dn);
        logic [H_W-1:0] h;
        h = H_W'(p);
        if (up && !dn) begin
            h = h >> 1;
        end else if (dn && !up) begin
            h = h << 1;
        end
        if ((p != '0) && (h == '0)) begin
            h = H_W'(1);
        end
        return h;
    endfunction

    // Any voice with a nonzero period counts as active.
    always_comb begin
        any_active = 1'b0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            any_active = any_active | (period_q[i] != '0);
        end
    end

    // Per-voice period register, half-period counter and raw tone.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        raw_d    = raw_q;
        half_c   = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            half_c[i] = eff_half(period_q[i], octave_up, octave_down);
            if (wr_en && (wr_sel == SEL_W'(i))) begin
                period_d[i] = wr_period;
                cnt_d[i]    = '0;
                raw_d[i]    = 1'b0;
            end else if (period_q[i] == '0) begin
                cnt_d[i] = '0;
                raw_d[i] = 1'b0;
            end else if (cnt_q[i] >= (half_c[i] - H_W'(1))) begin
                // ">=" so a shrinking half-period wraps on the very next edge
                cnt_d[i] = '0;
                raw_d[i] = ~raw_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + H_W'(1);
            end
        end
    end

    // LFO, tremolo gate and LED. voice_out tracks the tone registered this edge.
    always_comb begin
        lfo_d   = lfo_q + TREM_W'(1);
        gate_c  = ~tremolo_en | lfo_d[TREM_W-1];
        voice_d = raw_d & {NUM_VOICES{gate_c}};
        led_d   = led_en & any_active & lfo_q[TREM_W-1];
    end

`ifdef MUSIC_VOICE_BANK_STEREO_EN
    localparam int unsigned HALF_V = NUM_VOICES / 2;

    logic [ACC_W-1:0] acc_r_q, acc_r_d;
    logic             mix_r_q, mix_r_d;
    logic [SUM_W-1:0] sum_l_c, sum_r_c;

    // Two first-order sigma-delta channels: even voices left, odd voices right.
    always_comb begin
        sum_l_c = SUM_W'(acc_q);
        sum_r_c = SUM_W'(acc_r_q);
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if ((i % 2) == 0) begin
                sum_l_c = sum_l_c + SUM_W'(voice_q[i]);
            end else begin
                sum_r_c = sum_r_c + SUM_W'(voice_q[i]);
            end
        end
        if (sum_l_c >= SUM_W'(HALF_V)) begin
            mix_d = 1'b1;
            acc_d = ACC_W'(sum_l_c - SUM_W'(HALF_V));
        end else begin
            mix_d = 1'b0;
            acc_d = ACC_W'(sum_l_c);
        end
        if (sum_r_c >= SUM_W'(HALF_V)) begin
            mix_r_d = 1'b1;
            acc_r_d = ACC_W'(sum_r_c - SUM_W'(HALF_V));
        end else begin
            mix_r_d = 1'b0;
            acc_r_d = ACC_W'(sum_r_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r_q <= '0;
            mix_r_q <= 1'b0;
        end else begin
            acc_r_q <= acc_r_d;
            mix_r_q <= mix_r_d;
        end
    end

    assign mix_out_r = mix_r_q;
`else
    logic [SUM_W-1:0] sum_c;

    // First-order sigma-delta: emit 1 whenever the running total crosses NUM_VOICES.
    always_comb begin
        sum_c = SUM_W'(acc_q);
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            sum_c = sum_c + SUM_W'(voice_q[i]);
        end
        if (sum_c >= SUM_W'(NUM_VOICES)) begin
            mix_d = 1'b1;
            acc_d = ACC_W'(sum_c - SUM_W'(NUM_VOICES));
        end else begin
            mix_d = 1'b0;
            acc_d = ACC_W'(sum_c);
        end
    end
`endif

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            cnt_q    <= '0;
            raw_q    <= '0;
            voice_q  <= '0;
            lfo_q    <= '0;
            acc_q    <= '0;
            mix_q    <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            raw_q    <= raw_d;
            voice_q  <= voice_d;
            lfo_q    <= lfo_d;
            acc_q    <= acc_d;
            mix_q    <= mix_d;
            led_q    <= led_d;
        end
    end

    assign voice_out = voice_q;
    assign mix_out   = mix_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_music_voice_bank.sv
// Testbench for music_voice_bank (NUM_VOICES=4, PERIOD_W=12, TREM_W=4).
// Directed scenarios plus randomized traffic, checked against a
// cycle-level behavioural model of tone timing, LFO, LED and mixing.
module tb_music_voice_bank;

    localparam int NV = 4;
    localparam int PW = 12;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [PW-1:0] wr_period;
    logic          octave_up;
    logic          octave_down;
    logic          tremolo_en;
    logic          led_en;
    logic [NV-1:0] voice_out;
    logic          mix_out;
    logic          any_active;
    logic          led_out;
`ifdef MUSIC_VOICE_BANK_STEREO_EN
    logic          mix_out_r;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    music_voice_bank #(
        .NUM_VOICES (NV),
        .PERIOD_W   (PW),
        .TREM_W     (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_period   (wr_period),
        .octave_up   (octave_up),
        .octave_down (octave_down),
        .tremolo_en  (tremolo_en),
        .led_en      (led_en),
        .voice_out   (voice_out),
        .mix_out     (mix_out),
        .any_active  (any_active),
        .led_out     (led_out)
`ifdef MUSIC_VOICE_BANK_STEREO_EN
        ,
        .mix_out_r   (mix_out_r)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Tones are tracked by absolute time of the last toggle/restart; the
    // mixer by the cumulative sum of active voices (a 1 is emitted each time
    // the running total crosses a multiple of the divisor).
    int            m_now = 0;
    int            m_period[NV];
    int            m_start[NV];
    bit            m_raw[NV];
    logic [NV-1:0] m_vout;
    int            m_lfo;
    longint        m_tot, m_tot_l, m_tot_r;
    logic          m_mix, m_mix_r, m_led;

    function automatic int m_half(int p, bit up, bit dn);
        int h;
        h = p;
        if (up && !dn) h = p / 2;
        else if (dn && !up) h = p * 2;
        if (p != 0 && h == 0) h = 1;
        return h;
    endfunction

    task automatic tick();
        logic r, we, up, dn, tr, le;
        logic [1:0] sel;
        int wp, s, sl, sr, h;
        bit msb_old, msb_new, act_old;
        r = rst; we = wr_en; sel = wr_sel; wp = int'(wr_period);
        up = octave_up; dn = octave_down; tr = tremolo_en; le = led_en;
        @(posedge clk);
        #1;
        m_now++;
        if (r) begin
            for (int i = 0; i < NV; i++) begin
                m_period[i] = 0; m_raw[i] = 1'b0; m_start[i] = m_now;
            end
            m_vout = '0; m_lfo = 0; m_tot = 0; m_tot_l = 0; m_tot_r = 0;
            m_mix = 1'b0; m_mix_r = 1'b0; m_led = 1'b0;
        end else begin
            msb_old = ((m_lfo % 16) >= 8);
            act_old = 1'b0;
            for (int i = 0; i < NV; i++) if (m_period[i] != 0) act_old = 1'b1;
            s  = $countones(m_vout);
            sl = int'(m_vout[0]) + int'(m_vout[2]);
            sr = int'(m_vout[1]) + int'(m_vout[3]);
            m_mix   = ((m_tot + s) / NV) != (m_tot / NV);
            m_tot   = m_tot + s;
            m_mix_r = ((m_tot_r + sr) / (NV / 2)) != (m_tot_r / (NV / 2));
            m_tot_r = m_tot_r + sr;
`ifdef MUSIC_VOICE_BANK_STEREO_EN
            m_mix   = ((m_tot_l + sl) / (NV / 2)) != (m_tot_l / (NV / 2));
            m_tot_l = m_tot_l + sl;
`endif
            m_led = le && act_old && msb_old;
            m_lfo++;
            msb_new = ((m_lfo % 16) >= 8);
            for (int i = 0; i < NV; i++) begin
                h = m_half(m_period[i], up, dn);
                if (we && int'(sel) == i) begin
                    m_period[i] = wp; m_start[i] = m_now; m_raw[i] = 1'b0;
                end else if (m_period[i] == 0) begin
                    m_raw[i] = 1'b0; m_start[i] = m_now;
                end else if (m_now - m_start[i] >= h) begin
                    m_raw[i] = ~m_raw[i]; m_start[i] = m_now;
                end
                m_vout[i] = m_raw[i] & (!tr || msb_new);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; octave_up = 1'b0; octave_down = 1'b0;
        tremolo_en = 1'b0; led_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input int sel, input int p);
        wr_en = 1'b1; wr_sel = 2'(sel); wr_period = PW'(p);
        tick();
        wr_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_period = 12'd5;
        octave_up = 1'b0; octave_down = 1'b0; tremolo_en = 1'b0; led_en = 1'b1;
        tick(); tick();
        rst = 1'b0; wr_en = 1'b0;
        n_tests++; if (voice_out !== 4'b0000) begin n_fail++; $display("FAIL reset_voice: got %b expected 0000", voice_out); end
        n_tests++; if (mix_out !== 1'b0) begin n_fail++; $display("FAIL reset_mix: got %b expected 0", mix_out); end
        n_tests++; if (led_out !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b expected 0", led_out); end
        n_tests++; if (any_active !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ignored: any_active got %b expected 0", any_active); end
        led_en = 1'b0;
    endtask

    task automatic test_single_voice();
        logic exp;
        do_reset();
        do_write(0, 3);
        n_tests++; if (voice_out[0] !== 1'b0) begin n_fail++; $display("FAIL single_e0: got %b expected 0", voice_out[0]); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = ((k / 3) % 2) == 1;
            n_tests++; if (voice_out[0] !== exp) begin n_fail++; $display("FAIL single_timing E%0d: got %b expected %b", k, voice_out[0], exp); end
            n_tests++; if (voice_out[3:1] !== 3'b000) begin n_fail++; $display("FAIL single_others E%0d: got %b expected 000", k, voice_out[3:1]); end
            n_tests++; if (any_active !== 1'b1) begin n_fail++; $display("FAIL single_active E%0d: got %b expected 1", k, any_active); end
        end
    endtask

    task automatic test_octave();
        bit ups[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit dns[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        int exph[4] = '{2, 8, 4, 1};
        int tog[$];
        logic prev;
        do_reset();
        do_write(1, 4);
        for (int t = 0; t < 4; t++) begin
            octave_up = ups[t]; octave_down = dns[t];
            if (t == 3) do_write(1, 1);
            tog.delete();
            prev = voice_out[1];
            for (int c = 0; c < 60 && tog.size() < 3; c++) begin
                tick();
                n_tests++; if (voice_out !== m_vout) begin n_fail++; $display("FAIL octave_model case%0d: got %b expected %b", t, voice_out, m_vout); end
                if (voice_out[1] !== prev) begin tog.push_back(c); prev = voice_out[1]; end
            end
            n_tests++;
            if (tog.size() < 3) begin
                n_fail++; $display("FAIL octave_timeout case%0d: got %0d toggles expected 3", t, tog.size());
            end else if (tog[2] - tog[1] != exph[t]) begin
                n_fail++; $display("FAIL octave_half case%0d: got %0d expected %0d", t, tog[2] - tog[1], exph[t]);
            end
        end
        octave_up = 1'b0; octave_down = 1'b0;
    endtask

    task automatic test_tremolo_led();
        int highs, leds;
        highs = 0; leds = 0;
        do_reset();
        tremolo_en = 1'b1; led_en = 1'b1;
        do_write(0, 1);
        for (int c = 0; c < 40; c++) begin
            tick();
            n_tests++; if (voice_out[0] !== m_vout[0]) begin n_fail++; $display("FAIL trem_voice c%0d: got %b expected %b", c, voice_out[0], m_vout[0]); end
            n_tests++; if (led_out !== m_led) begin n_fail++; $display("FAIL trem_led c%0d: got %b expected %b", c, led_out, m_led); end
            if (voice_out[0] === 1'b1) highs++;
            if (led_out === 1'b1) leds++;
        end
        n_tests++; if (highs == 0 || leds == 0) begin n_fail++; $display("FAIL trem_activity: got highs=%0d leds=%0d expected both nonzero", highs, leds); end
        tremolo_en = 1'b0; led_en = 1'b0;
    endtask

    task automatic test_mixer();
        logic [NV-1:0] prev;
        int ones, c;
        do_reset();
        for (int v = 0; v < NV; v++) do_write(v, 5);
        for (int k = 0; k < 40; k++) begin
            prev = voice_out;
            tick();
            n_tests++; if (mix_out !== m_mix) begin n_fail++; $display("FAIL mix_model k%0d: got %b expected %b", k, mix_out, m_mix); end
            if (prev == 4'hF) begin
                n_tests++; if (mix_out !== 1'b1) begin n_fail++; $display("FAIL mix_allhigh k%0d: got %b expected 1", k, mix_out); end
            end else if (prev == 4'h0) begin
                n_tests++; if (mix_out !== 1'b0) begin n_fail++; $display("FAIL mix_alllow k%0d: got %b expected 0", k, mix_out); end
            end
        end
        for (int v = 1; v < NV; v++) do_write(v, 0);
        do_write(0, 200);
        c = 0;
        while (voice_out !== 4'b0001 && c < 250) begin tick(); c++; end
        n_tests++; if (voice_out !== 4'b0001) begin n_fail++; $display("FAIL mix_wait: got %b expected 0001", voice_out); end
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (mix_out === 1'b1) ones++;
        end
        n_tests++; if (ones != 4) begin n_fail++; $display("FAIL mix_quarter: got %0d ones expected 4", ones); end
    endtask

    task automatic test_mid_events();
        int c;
        logic exp;
        do_reset();
        do_write(2, 7);
        c = 0;
        while (voice_out[2] !== 1'b1 && c < 30) begin tick(); c++; end
        n_tests++; if (voice_out[2] !== 1'b1) begin n_fail++; $display("FAIL mid_wait: got %b expected 1", voice_out[2]); end
        tick(); tick();
        do_write(2, 7);
        n_tests++; if (voice_out[2] !== 1'b0) begin n_fail++; $display("FAIL mid_rewrite_low: got %b expected 0", voice_out[2]); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = (k == 7);
            n_tests++; if (voice_out[2] !== exp) begin n_fail++; $display("FAIL mid_restart E%0d: got %b expected %b", k, voice_out[2], exp); end
        end
        do_write(2, 0);
        n_tests++; if (voice_out[2] !== 1'b0) begin n_fail++; $display("FAIL mid_mute: got %b expected 0", voice_out[2]); end
        n_tests++; if (any_active !== 1'b0) begin n_fail++; $display("FAIL mid_inactive: got %b expected 0", any_active); end
        led_en = 1'b1;
        do_write(0, 2);
        c = 0;
        while (voice_out[0] !== 1'b1 && c < 20) begin tick(); c++; end
        n_tests++; if (voice_out[0] !== 1'b1) begin n_fail++; $display("FAIL mid_wait2: got %b expected 1", voice_out[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (voice_out !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_voice: got %b expected 0000", voice_out); end
        n_tests++; if (mix_out !== 1'b0 || led_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mixled: got mix=%b led=%b expected 0 0", mix_out, led_out); end
        n_tests++; if (any_active !== 1'b0) begin n_fail++; $display("FAIL mid_rst_active: got %b expected 0", any_active); end
        led_en = 1'b0;
    endtask

    task automatic test_random();
        logic exp_act;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            wr_en     = ($urandom % 6) == 0;
            wr_sel    = 2'($urandom);
            wr_period = (($urandom % 4) == 0) ? 12'd0 : PW'($urandom_range(1, 12));
            if (($urandom % 25) == 0) begin octave_up = 1'($urandom); octave_down = 1'($urandom); end
            if (($urandom % 40) == 0) tremolo_en = 1'($urandom);
            if (($urandom % 40) == 0) led_en = 1'($urandom);
            rst = ($urandom % 150) == 0;
            tick();
            exp_act = 1'b0;
            for (int i = 0; i < NV; i++) if (m_period[i] != 0) exp_act = 1'b1;
            n_tests++; if (voice_out !== m_vout) begin n_fail++; $display("FAIL rand_voice c%0d: got %b expected %b", c, voice_out, m_vout); end
            n_tests++; if (mix_out !== m_mix) begin n_fail++; $display("FAIL rand_mix c%0d: got %b expected %b", c, mix_out, m_mix); end
            n_tests++; if (led_out !== m_led) begin n_fail++; $display("FAIL rand_led c%0d: got %b expected %b", c, led_out, m_led); end
            n_tests++; if (any_active !== exp_act) begin n_fail++; $display("FAIL rand_active c%0d: got %b expected %b", c, any_active, exp_act); end
`ifdef MUSIC_VOICE_BANK_STEREO_EN
            n_tests++; if (mix_out_r !== m_mix_r) begin n_fail++; $display("FAIL rand_mix_r c%0d: got %b expected %b", c, mix_out_r, m_mix_r); end
`endif
        end
        rst = 1'b0; wr_en = 1'b0;
    endtask

`ifdef MUSIC_VOICE_BANK_STEREO_EN
    task automatic test_stereo();
        int c;
        logic prev;
        do_reset();
        do_write(0, 100);
        do_write(2, 100);
        c = 0;
        while (voice_out !== 4'b0101 && c < 150) begin tick(); c++; end
        n_tests++; if (voice_out !== 4'b0101) begin n_fail++; $display("FAIL st_wait02: got %b expected 0101", voice_out); end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++; if (mix_out !== 1'b1 || mix_out_r !== 1'b0) begin n_fail++; $display("FAIL st_even k%0d: got l=%b r=%b expected 1 0", k, mix_out, mix_out_r); end
        end
        do_reset();
        do_write(1, 100);
        c = 0;
        while (voice_out !== 4'b0010 && c < 150) begin tick(); c++; end
        n_tests++; if (voice_out !== 4'b0010) begin n_fail++; $display("FAIL st_wait1: got %b expected 0010", voice_out); end
        tick();
        prev = mix_out_r;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++; if (mix_out_r !== ~prev || mix_out_r !== m_mix_r) begin n_fail++; $display("FAIL st_odd k%0d: got %b expected %b", k, mix_out_r, ~prev); end
            n_tests++; if (mix_out !== 1'b0) begin n_fail++; $display("FAIL st_left_quiet k%0d: got %b expected 0", k, mix_out); end
            prev = mix_out_r;
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 2'd0; wr_period = '0;
        octave_up = 1'b0; octave_down = 1'b0; tremolo_en = 1'b0; led_en = 1'b0;
        m_vout = '0; m_lfo = 0; m_tot = 0; m_tot_l = 0; m_tot_r = 0;
        m_mix = 1'b0; m_mix_r = 1'b0; m_led = 1'b0;
        for (int i = 0; i < NV; i++) begin m_period[i] = 0; m_start[i] = 0; m_raw[i] = 1'b0; end
        test_reset();
        test_single_voice();
        test_octave();
        test_tremolo_led();
        test_mixer();
        test_mid_events();
        test_random();
`ifdef MUSIC_VOICE_BANK_STEREO_EN
        test_stereo();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
